// File: rtl/pbkdf2_sha256_multiblock.sv
// PBKDF2-HMAC-SHA256 (c=1) controller: walks block indices 1..OUT_BLOCKS through one
// external HMAC core and assembles the derived key with T1 in the MSBs.
module pbkdf2_sha256_multiblock #(
  parameter int unsigned PASS_W     = 640,
  parameter int unsigned SALT_W     = 1024,
  parameter int unsigned OUT_BLOCKS = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           enable,
  input  logic [PASS_W-1:0]              pass,
  input  logic [SALT_W-1:0]              salt,
  output logic                           busy,
  output logic [256*OUT_BLOCKS-1:0]      hash,
  output logic                           hash_done,
  output logic [PASS_W+SALT_W+32-1:0]    hmac_data,
  output logic                           hmac_start,
  input  logic                           hmac_done,
  input  logic [255:0]                   hmac_hash
);

  localparam int unsigned IdxW  = $clog2(OUT_BLOCKS + 1);
  localparam int unsigned HashW = 256 * OUT_BLOCKS;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [SALT_W-1:0]   salt_q, salt_d;
  logic [HashW-1:0]    hash_q, hash_d;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pass_q  <= '0;
      salt_q  <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      salt_q  <= salt_d;
      hash_q  <= hash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    salt_d  = salt_q;
    hash_d  = hash_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          pass_d  = pass;
          salt_d  = salt;
          idx_d   = IdxW'(1);
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (hmac_done) begin
          // Block idx lands in slot OUT_BLOCKS-idx counted from the LSB end.
          for (int b = 0; b < int'(OUT_BLOCKS); b++) begin
            if (idx_q == IdxW'(OUT_BLOCKS - 32'(b))) begin
              hash_d[256*b +: 256] = hmac_hash;
            end
          end
          if (idx_q == IdxW'(OUT_BLOCKS)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign hmac_start = (state_q == StIssue);
  assign hash_done  = (state_q == StDone);
  assign hash       = hash_q;
  assign hmac_data  = {pass_q, salt_q, {(32 - IdxW){1'b0}}, idx_q};

endmodule

// File: tb/tb_pbkdf2_sha256_multiblock.sv
// Directed bench: two controller instances (4-block and 1-block) driven by HMAC stubs that
// return {8{idx}} after a programmable latency.
module tb_pbkdf2_sha256_multiblock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // 4-block instance (80 -> 128 byte pass)
  logic           en0;
  logic [639:0]   pass0;
  logic [1023:0]  salt0;
  logic           busy0, done0, start0;
  logic [1023:0]  hash0;
  logic [1695:0]  data0;
  logic           sd0, inj0;
  logic [255:0]   shash0, sh0;
  logic           hdone0;
  logic [255:0]   hhash0;

  // 1-block instance (128 -> 32 byte pass)
  logic           en1;
  logic [1023:0]  pass1;
  logic [1023:0]  salt1;
  logic           busy1, done1, start1;
  logic [255:0]   hash1;
  logic [2079:0]  data1;
  logic           sd1;
  logic [255:0]   shash1, sh1;

  assign hdone0 = sd0 | inj0;
  assign hhash0 = inj0 ? {8{32'hdeadbeef}} : shash0;

  pbkdf2_sha256_multiblock #(.PASS_W(640), .SALT_W(1024), .OUT_BLOCKS(4)) u_dut0 (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (en0),
    .pass       (pass0),
    .salt       (salt0),
    .busy       (busy0),
    .hash       (hash0),
    .hash_done  (done0),
    .hmac_data  (data0),
    .hmac_start (start0),
    .hmac_done  (hdone0),
    .hmac_hash  (hhash0)
  );

  pbkdf2_sha256_multiblock #(.PASS_W(1024), .SALT_W(1024), .OUT_BLOCKS(1)) u_dut1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (en1),
    .pass       (pass1),
    .salt       (salt1),
    .busy       (busy1),
    .hash       (hash1),
    .hash_done  (done1),
    .hmac_data  (data1),
    .hmac_start (start1),
    .hmac_done  (sd1),
    .hmac_hash  (shash1)
  );

  // HMAC stubs: done is high in cycle start_cycle + L.
  int lat0 = 10;
  int lat1 = 10;
  bit rnd0 = 1'b0;
  int l0;
  int sumlat0 = 0;

  initial begin : stub0
    sd0 = 1'b0;
    shash0 = '0;
    forever begin
      @(negedge clk);
      if (start0) begin
        l0 = rnd0 ? int'($urandom_range(64, 1)) : lat0;
        sumlat0 = sumlat0 + l0 + 1;
        sh0 = {8{data0[31:0]}};
        @(posedge clk);
        repeat (l0 - 1) @(posedge clk);
        #1 sd0 = 1'b1;
        shash0 = sh0;
        @(posedge clk);
        #1 sd0 = 1'b0;
      end
    end
  end

  initial begin : stub1
    sd1 = 1'b0;
    shash1 = '0;
    forever begin
      @(negedge clk);
      if (start1) begin
        sh1 = {8{data1[31:0]}};
        @(posedge clk);
        repeat (lat1 - 1) @(posedge clk);
        #1 sd1 = 1'b1;
        shash1 = sh1;
        @(posedge clk);
        #1 sd1 = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run bookkeeping filled in by run0
  int           st_cyc[8];
  int           st_idx[8];
  int           nst;
  int           dcyc;
  int           nbusy;
  bit           fields_ok;
  bit           chg = 1'b0;
  bit           inj_issue = 1'b0;
  logic [639:0] cap_pass;
  logic [1023:0] cap_salt;

  task automatic run0(input bit hold);
    nst = 0;
    dcyc = -1;
    nbusy = 0;
    fields_ok = 1'b1;
    cap_pass = pass0;
    cap_salt = salt0;
    @(posedge clk);
    #1 en0 = 1'b1;
    @(posedge clk);
    #1 if (!hold) en0 = 1'b0;
    for (int n = 1; n < 3000; n++) begin
      @(negedge clk);
      if (busy0) nbusy++;
      if (start0) begin
        if (nst < 8) begin
          st_cyc[nst] = n;
          st_idx[nst] = int'(data0[31:0]);
        end
        nst++;
        if (data0[1695:1056] !== cap_pass || data0[1055:32] !== cap_salt) fields_ok = 1'b0;
        if (inj_issue && n == 1) inj0 = 1'b1;
      end
      if (done0) begin
        dcyc = n;
        break;
      end
      if (chg && n == 20) pass0 = ~pass0;
      @(posedge clk);
      #1 inj0 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  logic [1023:0] exp_h0;
  logic [255:0]  exp_h1;
  int            n1_st, n1_done, n1_idx;
  int            cnt_done, cnt_busy;

  initial begin
    n_rst = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    inj0 = 1'b0;
    pass0 = {20{32'h1234abcd}};
    salt0 = {32{32'h0f1e2d3c}};
    pass1 = {32{32'h55aa0ff0}};
    salt1 = {32{32'h600dcafe}};
    exp_h0 = {{8{32'h1}}, {8{32'h2}}, {8{32'h3}}, {8{32'h4}}};
    exp_h1 = {8{32'h1}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 1024'(busy0), 1024'(0));
    check("rst_hash_done", 1024'(done0), 1024'(0));
    check("rst_hmac_start", 1024'(start0), 1024'(0));
    check("rst_hash", hash0, '0);
    check("rst_hmac_data", 1024'(|data0), 1024'(0));
    @(posedge clk);
    #1 n_rst = 1'b1;

    // Basic 4-block run, L=10
    run0(1'b0);
    check("t1_nstart", 1024'(nst), 1024'(4));
    check("t1_start_c1", 1024'(st_cyc[0]), 1024'(1));
    check("t1_start_c2", 1024'(st_cyc[1]), 1024'(12));
    check("t1_start_c3", 1024'(st_cyc[2]), 1024'(23));
    check("t1_start_c4", 1024'(st_cyc[3]), 1024'(34));
    check("t1_idx1", 1024'(st_idx[0]), 1024'(1));
    check("t1_idx2", 1024'(st_idx[1]), 1024'(2));
    check("t1_idx3", 1024'(st_idx[2]), 1024'(3));
    check("t1_idx4", 1024'(st_idx[3]), 1024'(4));
    check("t1_fields", 1024'(fields_ok), 1024'(1));
    check("t1_done_cyc", 1024'(dcyc), 1024'(45));
    check("t1_busy_cycles", 1024'(nbusy), 1024'(45));
    check("t1_hash", hash0, exp_h0);
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_after", 1024'(busy0), 1024'(0));
    check("t1_done_pulse", 1024'(done0), 1024'(0));

    // Single-block instance
    n1_st = 0;
    n1_done = -1;
    n1_idx = -1;
    @(posedge clk);
    #1 en1 = 1'b1;
    @(posedge clk);
    #1 en1 = 1'b0;
    for (int n = 1; n < 200; n++) begin
      @(negedge clk);
      if (start1) begin
        if (n1_st == 0) n1_idx = n;
        n1_st++;
        check("t2_data_idx", 1024'(data1[31:0]), 1024'(1));
        check("t2_data_pass", data1[2079:1056], pass1);
      end
      if (done1) begin
        n1_done = n;
        break;
      end
      @(posedge clk);
    end
    check("t2_nstart", 1024'(n1_st), 1024'(1));
    check("t2_start_cyc", 1024'(n1_idx), 1024'(1));
    check("t2_done_cyc", 1024'(n1_done), 1024'(12));
    check("t2_hash", 1024'(hash1), 1024'(exp_h1));

    // Enable held high, password changed mid-run
    chg = 1'b1;
    run0(1'b1);
    chg = 1'b0;
    check("t3_nstart", 1024'(nst), 1024'(4));
    check("t3_fields", 1024'(fields_ok), 1024'(1));
    check("t3_done_cyc", 1024'(dcyc), 1024'(45));
    @(posedge clk);
    @(negedge clk);
    check("t3_idle_gap", 1024'(busy0), 1024'(0));
    @(posedge clk);
    @(negedge clk);
    check("t3_restart", 1024'(start0), 1024'(1));
    en0 = 1'b0;
    cnt_done = 0;
    for (int n = 0; n < 200 && cnt_done == 0; n++) begin
      @(negedge clk);
      if (done0) cnt_done++;
    end
    check("t3_second_done", 1024'(cnt_done), 1024'(1));
    pass0 = {20{32'h1234abcd}};

    // Spurious hmac_done in IDLE and in ISSUE
    do_reset();
    @(posedge clk);
    #1 inj0 = 1'b1;
    @(posedge clk);
    #1 inj0 = 1'b0;
    @(negedge clk);
    check("t4_idle_busy", 1024'(busy0), 1024'(0));
    check("t4_idle_hash", hash0, '0);
    inj_issue = 1'b1;
    run0(1'b0);
    inj_issue = 1'b0;
    check("t4_nstart", 1024'(nst), 1024'(4));
    check("t4_done_cyc", 1024'(dcyc), 1024'(45));
    check("t4_hash", hash0, exp_h0);

    // Reset during WAIT of block 2, stale done afterwards
    @(posedge clk);
    #1 en0 = 1'b1;
    @(posedge clk);
    #1 en0 = 1'b0;
    repeat (14) @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 1024'(busy0), 1024'(0));
    check("t5_hash", hash0, '0);
    cnt_done = 0;
    cnt_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0) cnt_done++;
      if (busy0) cnt_busy++;
    end
    check("t5_no_done", 1024'(cnt_done), 1024'(0));
    check("t5_stay_idle", 1024'(cnt_busy), 1024'(0));
    check("t5_hash_after", hash0, '0);
    run0(1'b0);
    check("t5_rerun_done", 1024'(dcyc), 1024'(45));
    check("t5_rerun_hash", hash0, exp_h0);

    // Random latency per request
    rnd0 = 1'b1;
    sumlat0 = 0;
    pass0 = {20{32'hc0ffee11}};
    run0(1'b0);
    rnd0 = 1'b0;
    check("t6_nstart", 1024'(nst), 1024'(4));
    check("t6_fields", 1024'(fields_ok), 1024'(1));
    check("t6_done_cyc", 1024'(dcyc), 1024'(sumlat0 + 1));
    check("t6_hash", hash0, exp_h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
